// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, instruction memory, hazard/branch logic and decode.
// The fetch stage takes the master side of the bundle.
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Build option BRANCH_DELAY_SLOT_EN keeps the IF instruction on a taken branch instead of flushing it.
//
// state  | meaning
// Run    | fetching one word per cycle unless stalled or redirected
// Halted | HALT word seen; PC frozen, IF/ID emits bubbles until a branch restarts fetch
module fetch_stage (
  input  logic          SysCLK,
  input  logic          RST,
  fetch_stage_if.master bus
);

  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  typedef enum logic {
    Run    = 1'b0,
    Halted = 1'b1
  } fetchState_t;

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] redirectPc;
  logic        isHalt;
  logic        keepSlot;
  logic [31:0] instrReg;
  logic [31:0] pc4Reg;
  logic        validReg;
  logic        haltedReg;

  assign pcPlus4    = pc + 32'd4;
  assign redirectPc = bus.branch_target & ~32'd3;
  assign isHalt     = (bus.imem_rdata == HaltWord);
  // A HALT word in the delay slot is dropped so a redirect never halts the core.
  assign keepSlot   = DelaySlot && !isHalt;

  assign bus.imem_addr  = RST ? 7'd0 : pc[8:2];
  assign bus.ifid_instr = instrReg;
  assign bus.ifid_pc4   = pc4Reg;
  assign bus.ifid_valid = validReg;
  assign bus.halted     = haltedReg;

  always_ff @(posedge SysCLK) begin
    if (RST) begin
      state     <= Run;
      pc        <= 32'd0;
      instrReg  <= 32'd0;
      pc4Reg    <= 32'd0;
      validReg  <= 1'b0;
      haltedReg <= 1'b0;
    end else begin
      case (state)
        Run: begin
          if (bus.branch_taken) begin
            pc <= redirectPc;
            if (keepSlot) begin
              instrReg <= bus.imem_rdata;
              pc4Reg   <= pcPlus4;
              validReg <= 1'b1;
            end else begin
              instrReg <= 32'd0;
              pc4Reg   <= 32'd0;
              validReg <= 1'b0;
            end
          end else if (!bus.stall) begin
            instrReg <= bus.imem_rdata;
            pc4Reg   <= pcPlus4;
            validReg <= 1'b1;
            if (isHalt) begin
              state     <= Halted;
              haltedReg <= 1'b1;
            end else begin
              pc <= pcPlus4;
            end
          end
        end
        Halted: begin
          instrReg <= 32'd0;
          pc4Reg   <= 32'd0;
          validReg <= 1'b0;
          if (bus.branch_taken) begin
            pc        <= redirectPc;
            state     <= Run;
            haltedReg <= 1'b0;
          end
        end
        default: begin
          state     <= Run;
          haltedReg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: rule-level reference model compared every cycle plus literal pins.
module tb_fetch_stage;
  logic SysCLK;
  logic RST;
  fetch_stage_if bus ();

  logic [31:0] imem [128];
  assign bus.imem_rdata = imem[bus.imem_addr];

  fetch_stage dut (
    .SysCLK (SysCLK),
    .RST    (RST),
    .bus    (bus)
  );

  initial begin
    SysCLK = 1'b0;
    forever #5 SysCLK = ~SysCLK;
  end

  int nRun  = 0;
  int nFail = 0;
  bit chkEn = 1'b0;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit Ds = 1'b1;
`else
  localparam bit Ds = 1'b0;
`endif

  // Reference model: architectural state advanced by the fetch rules.
  logic [31:0] mPc, mInstr, mPc4;
  logic        mValid, mHalt;

  always @(posedge SysCLK) begin
    logic [31:0] word;
    logic [31:0] next4;
    word  = imem[(mPc >> 2) % 128];
    next4 = mPc + 32'd4;
    if (RST) begin
      mPc = 0; mInstr = 0; mPc4 = 0; mValid = 0; mHalt = 0;
    end else if (mHalt) begin
      mInstr = 0; mPc4 = 0; mValid = 0;
      if (bus.branch_taken) begin
        mPc   = {bus.branch_target[31:2], 2'b00};
        mHalt = 0;
      end
    end else if (bus.branch_taken) begin
      if (Ds && word != 32'hFFFFFFFF) begin
        mInstr = word; mPc4 = next4; mValid = 1;
      end else begin
        mInstr = 0; mPc4 = 0; mValid = 0;
      end
      mPc = {bus.branch_target[31:2], 2'b00};
    end else if (!bus.stall) begin
      mInstr = word; mPc4 = next4; mValid = 1;
      if (word == 32'hFFFFFFFF) mHalt = 1;
      else mPc = next4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge SysCLK) begin
    if (chkEn) begin
      chk("cmp_addr",   {25'd0, bus.imem_addr}, RST ? 32'd0 : (mPc >> 2) % 128);
      chk("cmp_instr",  bus.ifid_instr, mInstr);
      chk("cmp_pc4",    bus.ifid_pc4, mPc4);
      chk("cmp_valid",  {31'd0, bus.ifid_valid}, {31'd0, mValid});
      chk("cmp_halted", {31'd0, bus.halted}, {31'd0, mHalt});
    end
  end

  task automatic step();
    @(posedge SysCLK);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    RST = r;
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = t;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'h1000_0000 + i;
    drive(1, 0, 0, 0);
    #1;
    chk("addr_in_reset", {25'd0, bus.imem_addr}, 32'd0);
    step();
    chkEn = 1'b1;
    step();
    chk("rst_instr", bus.ifid_instr, 32'd0);
    chk("rst_pc4", bus.ifid_pc4, 32'd0);
    chk("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);

    // free run from address 0
    drive(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("free_instr", bus.ifid_instr, 32'h1000_0000 + k);
      chk("free_pc4", bus.ifid_pc4, 4 * (k + 1));
      chk("free_valid", {31'd0, bus.ifid_valid}, 32'd1);
    end

    // stall three cycles at PC=8
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step(); step();
    chk("pre_stall_addr", {25'd0, bus.imem_addr}, 32'd2);
    drive(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_instr", bus.ifid_instr, 32'h1000_0001);
      chk("stall_addr", {25'd0, bus.imem_addr}, 32'd2);
    end
    drive(0, 0, 0, 0); step();
    chk("resume_instr", bus.ifid_instr, 32'h1000_0002);
    chk("resume_pc4", bus.ifid_pc4, 32'd12);

    // misaligned branch at PC=12
    drive(0, 0, 1, 32'h43); step();
    chk("br_addr", {25'd0, bus.imem_addr}, 32'd16);
    chk("br_valid", {31'd0, bus.ifid_valid}, {31'd0, Ds});
    chk("br_instr", bus.ifid_instr, Ds ? 32'h1000_0003 : 32'd0);
    drive(0, 0, 0, 0); step();
    chk("br_tgt_instr", bus.ifid_instr, 32'h1000_0010);
    chk("br_tgt_pc4", bus.ifid_pc4, 32'h44);

    // branch wins over stall
    drive(0, 1, 1, 32'h100); step();
    chk("brstall_addr", {25'd0, bus.imem_addr}, 32'd64);
    drive(0, 0, 0, 0); step();
    chk("brstall_instr", bus.ifid_instr, 32'h1000_0040);

    // HALT at word 5, restart at 0
    imem[5] = 32'hFFFF_FFFF;
    drive(0, 0, 1, 32'h10); step();
    drive(0, 0, 0, 0); step(); step();
    chk("halt_instr", bus.ifid_instr, 32'hFFFF_FFFF);
    chk("halt_valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("halt_flag", {31'd0, bus.halted}, 32'd1);
    drive(0, 1, 0, 0); step();
    chk("halted_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("halted_addr", {25'd0, bus.imem_addr}, 32'd5);
    step();
    drive(0, 0, 1, 32'h0); step();
    chk("restart_halted", {31'd0, bus.halted}, 32'd0);
    chk("restart_addr", {25'd0, bus.imem_addr}, 32'd0);
    drive(0, 0, 0, 0); step();
    chk("restart_instr", bus.ifid_instr, 32'h1000_0000);

    // HALT fetched together with a branch is dropped
    drive(0, 0, 1, 32'h14); step();
    drive(0, 0, 1, 32'h20); step();
    chk("halt_br_flag", {31'd0, bus.halted}, 32'd0);
    chk("halt_br_valid", {31'd0, bus.ifid_valid}, 32'd0);
    drive(0, 0, 0, 0); step();
    chk("halt_br_instr", bus.ifid_instr, 32'h1000_0008);

    // PC and word address wrap
    drive(0, 0, 1, 32'hFFFF_FFFA); step();
    chk("wrap_addr", {25'd0, bus.imem_addr}, 32'd126);
    drive(0, 0, 0, 0); step();
    chk("wrap_pc4_a", bus.ifid_pc4, 32'hFFFF_FFFC);
    step();
    chk("wrap_instr", bus.ifid_instr, 32'h1000_007F);
    chk("wrap_pc4_b", bus.ifid_pc4, 32'd0);
    step();
    chk("wrap_zero", bus.ifid_instr, 32'h1000_0000);

    // reset while halted, stalled and branching
    drive(0, 0, 1, 32'h14); step();
    drive(0, 0, 0, 0); step();
    chk("pre_rst_halt", {31'd0, bus.halted}, 32'd1);
    drive(1, 1, 1, 32'h40); step();
    chk("rst2_instr", bus.ifid_instr, 32'd0);
    chk("rst2_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst2_addr", {25'd0, bus.imem_addr}, 32'd0);
    drive(0, 0, 0, 0); step();
    chk("rst2_first", bus.ifid_instr, 32'h1000_0000);
    chk("rst2_pc4", bus.ifid_pc4, 32'd4);

    @(negedge SysCLK);
    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port SysCLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  input  1  from hazard unit; hold PC and IF/ID register.
REQ-004 SHALL have port branch_taken  input  1  redirect request from ID/EX.
REQ-005 SHALL have port branch_target  input  32  redirect byte address.
REQ-006 SHALL have port imem_addr  output  7  word address to instruction memory, equal to PC[8:2].
REQ-007 SHALL have port imem_rdata  input  32  combinational instruction read data for imem_addr.
REQ-008 SHALL have port ifid_instr  output  32  registered instruction to decode.
REQ-009 SHALL have port ifid_pc4  output  32  registered PC+4 of that instruction.
REQ-010 SHALL have port ifid_valid  output  1  ifid_instr is a real instruction, not a bubble.
REQ-011 SHALL have port halted  output  1  fetch stopped on HALT word.

Function
REQ-012 SHALL implement states RUN and HALTED; reset enters RUN.
REQ-013 In RUN, no stall, no branch: each cycle PC <= PC+4 mod 2^32; ifid_instr <= imem_rdata, ifid_pc4 <= PC+4, ifid_valid <= 1.
REQ-014 Fetch latency SHALL be one cycle: the word at PC appears on ifid_instr on the edge after PC is presented.
REQ-015 stall=1, branch_taken=0: PC and all ifid_* outputs SHALL hold unchanged.
REQ-016 branch_taken=1: PC <= {branch_target[31:2],2'b00}; misaligned low bits silently cleared.
REQ-017 branch_taken SHALL take priority over stall in the same cycle.
REQ-018 Flush (branch without delay slot, see REQ-027): ifid_instr <= 32'h00000000, ifid_valid <= 0, ifid_pc4 <= 0.
REQ-019 imem_addr SHALL wrap modulo 128 words; PC itself is full 32-bit and wraps 32'hFFFFFFFC -> 0.
REQ-020 HALT word 32'hFFFFFFFF fetched in RUN (no stall): SHALL be latched into IF/ID with ifid_valid=1, state -> HALTED, PC holds.
REQ-021 In HALTED: PC holds, ifid_instr <= 0, ifid_valid <= 0 every cycle, halted=1; stall ignored.
REQ-022 In HALTED, branch_taken=1 SHALL redirect PC and return to RUN (restart path); halted deasserts the following cycle.
REQ-023 HALT word fetched in the same cycle as branch_taken SHALL be discarded; state stays RUN.

Reset
REQ-024 RST=1 at a rising edge SHALL set PC=0, ifid_instr=0, ifid_pc4=0, ifid_valid=0, halted=0, state=RUN, overriding stall and branch_taken.
REQ-025 RST asserted mid-stall or in HALTED SHALL produce identical reset state; first fetch at address 0 on the first edge with RST=0.
REQ-026 imem_addr SHALL read 0 during reset.

Configuration
REQ-027 Macro BRANCH_DELAY_SLOT_EN: defined -> on branch_taken the instruction currently in IF is kept (ifid_valid=1, normal REQ-013 capture) and only PC redirects; undefined -> IF/ID flushed per REQ-018.
REQ-028 Without BRANCH_DELAY_SLOT_EN the taken-branch penalty SHALL be exactly one bubble; with it, zero bubbles.

Verification
REQ-029 Reset then 4 free cycles, imem[i]=32'h1000_0000+i -> ifid_instr sequence 10000000..10000003, ifid_pc4 4,8,12,16, ifid_valid=1.
REQ-030 stall=1 for 3 cycles at PC=8 -> ifid_instr holds 32'h10000001, PC stays 8, resumes with 32'h10000002.
REQ-031 branch_taken=1, branch_target=32'h43 at PC=12 -> next PC=32'h40; without macro one cycle ifid_valid=0, instr=0; with macro imem[3] passes with ifid_valid=1.
REQ-032 branch_taken and stall together -> PC redirected, stall ignored.
REQ-033 imem[5]=32'hFFFFFFFF -> halted=1 cycle after capture, ifid_valid=0 thereafter; branch_taken to 0 restarts fetch at imem[0].
REQ-034 RST pulsed while HALTED and stalled -> all outputs 0, next fetch address 0.
